pc_stack: RTL and testbench

Parametrised program counter with an N-byte address, a multi-byte high-address staging register, local/long jumps and a hardware call/return stack. It sits in the fetch path: it drives the instruction-memory address and takes jump targets from the 8-bit data bus D. It extends the original 16-bit counter with configurable address width, a stall input and subroutine call/return with overflow and underflow detection.

---
 rtl/pc_stack.sv | 145 ++++++++++++++
 tb/tb_pc_stack.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack.sv
// pc_stack: byte-wide program counter with PCHITMP staging,
// local/long jumps and a hardware call/return stack.
module pc_stack #(
    parameter  int ADDR_BYTES  = 2,
    parameter  int STACK_DEPTH = 4,
    localparam int AW          = 8 * ADDR_BYTES,
    localparam int DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          _MR,
    input  logic [7:0]    D,
    input  logic          _pchitmp_in,
    input  logic          _local_jump,
    input  logic          _long_jump,
    input  logic          _call,
    input  logic          _ret,
    input  logic          _hold,
    output logic [AW-1:0] PC,
    output logic [7:0]    PCLO,
    output logic [7:0]    PCHI,
    output logic [DW-1:0] depth,
    output logic          overflow,
    output logic          underflow
);

    localparam int HW = AW - 8;
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [AW-1:0] pc_q, pc_nxt, pc_inc, jump_tgt, top;
    logic [HW-1:0] hitmp_q, hitmp_nxt, hitmp_shl;
    logic [DW-1:0] depth_q, depth_nxt;
    logic [IW-1:0] wr_idx, rd_idx;
    logic          ovf_q, udf_q;
    logic          full, empty;
    logic          push, pop, set_ovf, set_udf;
    logic          hold_sel, ret_sel, call_sel;
    logic          long_sel, local_sel, inc_sel;
    logic [AW-1:0] stk [STACK_DEPTH];

    // Staging register shifts in one byte per load, MSB first.
    if (HW > 8) begin : g_shl
        assign hitmp_shl = {hitmp_q[HW-9:0], D};
    end else begin : g_ld
        assign hitmp_shl = D;
    end

    assign hitmp_nxt = _pchitmp_in ? hitmp_q : hitmp_shl;

    assign pc_inc   = pc_q + AW'(1);
    assign jump_tgt = {hitmp_q, D};
    assign full     = (depth_q == DW'(STACK_DEPTH));
    assign empty    = (depth_q == '0);
    assign wr_idx   = IW'(depth_q);
    assign rd_idx   = IW'(depth_q - DW'(1));
    assign top      = stk[rd_idx];

    // One-hot action select in priority order.
    assign hold_sel  = !_hold;
    assign ret_sel   = _hold && !_ret;
    assign call_sel  = _hold && _ret && !_call;
    assign long_sel  = _hold && _ret && _call && !_long_jump;
    assign local_sel = _hold && _ret && _call && _long_jump
                       && !_local_jump;
    assign inc_sel   = _hold && _ret && _call && _long_jump
                       && _local_jump;

    always_comb begin
        pc_nxt  = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        set_ovf = 1'b0;
        set_udf = 1'b0;
        unique case (1'b1)
            hold_sel: begin
                pc_nxt = pc_q;
            end
            ret_sel: begin
                if (!empty) begin
                    pc_nxt = top;
                    pop    = 1'b1;
                end else begin
                    pc_nxt  = pc_inc;
                    set_udf = 1'b1;
                end
            end
            call_sel: begin
                pc_nxt  = jump_tgt;
                push    = !full;
                set_ovf = full;
            end
            long_sel: begin
                pc_nxt = jump_tgt;
            end
            local_sel: begin
                pc_nxt = {pc_q[AW-1:8], D};
            end
            inc_sel: begin
                pc_nxt = pc_inc;
            end
            default: begin
                pc_nxt = pc_q;
            end
        endcase
    end

    always_comb begin
        depth_nxt = depth_q;
        if (push) begin
            depth_nxt = depth_q + DW'(1);
        end else if (pop) begin
            depth_nxt = depth_q - DW'(1);
        end
    end

    always_ff @(posedge clk or negedge _MR) begin
        if (!_MR) begin
            pc_q    <= '0;
            hitmp_q <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_nxt;
            hitmp_q <= hitmp_nxt;
            depth_q <= depth_nxt;
            ovf_q   <= ovf_q | set_ovf;
            udf_q   <= udf_q | set_udf;
        end
    end

    // Entry contents need no reset; depth marks what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            stk[wr_idx] <= pc_inc;
        end
    end

    assign PC        = pc_q;
    assign PCLO      = pc_q[7:0];
    assign PCHI      = pc_q[AW-1:AW-8];
    assign depth     = depth_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack: 16-bit and 24-bit instances
// share stimulus; expectations are hand-computed per width.
module tb_pc_stack;

    logic        clk;
    logic        mr_n;
    logic [7:0]  d;
    logic        pchitmp_in_n, local_n, long_n;
    logic        call_n, ret_n, hold_n;

    logic [15:0] pc2;
    logic [7:0]  pclo2, pchi2;
    logic [2:0]  depth2;
    logic        ovf2, udf2;

    logic [23:0] pc3;
    logic [7:0]  pclo3, pchi3;
    logic [2:0]  depth3;
    logic        ovf3, udf3;

    int checks   = 0;
    int failures = 0;

    pc_stack #(.ADDR_BYTES(2), .STACK_DEPTH(4)) u2 (
        .clk(clk), ._MR(mr_n), .D(d),
        ._pchitmp_in(pchitmp_in_n), ._local_jump(local_n),
        ._long_jump(long_n), ._call(call_n), ._ret(ret_n),
        ._hold(hold_n), .PC(pc2), .PCLO(pclo2), .PCHI(pchi2),
        .depth(depth2), .overflow(ovf2), .underflow(udf2)
    );

    pc_stack #(.ADDR_BYTES(3), .STACK_DEPTH(4)) u3 (
        .clk(clk), ._MR(mr_n), .D(d),
        ._pchitmp_in(pchitmp_in_n), ._local_jump(local_n),
        ._long_jump(long_n), ._call(call_n), ._ret(ret_n),
        ._hold(hold_n), .PC(pc3), .PCLO(pclo3), .PCHI(pchi3),
        .depth(depth3), .overflow(ovf3), .underflow(udf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        d = 8'h00;
        pchitmp_in_n = 1'b1;
        local_n = 1'b1;
        long_n = 1'b1;
        call_n = 1'b1;
        ret_n = 1'b1;
        hold_n = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mr_n = 1'b0;
        idle();
        repeat (3) tick();
        check("rst_pc2", pc2, 32'h0000);
        check("rst_pc3", pc3, 32'h000000);
        check("rst_depth", depth2, 32'd0);
        check("rst_flags", {ovf2, udf2}, 32'd0);

        mr_n = 1'b1;
        tick();
        tick();
        check("count_pc2", pc2, 32'h0002);
        check("count_pc3", pc3, 32'h000002);

        pchitmp_in_n = 1'b0; d = 8'hFF;
        tick();
        idle(); long_n = 1'b0; d = 8'hFE;
        tick();
        check("ljmp_fffe", pc2, 32'hFFFE);
        idle();
        tick();
        tick();
        check("wrap_pc2", pc2, 32'h0000);
        check("nowrap_pc3", pc3, 32'h010000);

        pchitmp_in_n = 1'b0; d = 8'h12;
        tick();
        d = 8'h34;
        tick();
        check("shift_inc_pc3", pc3, 32'h010002);
        idle(); long_n = 1'b0; d = 8'h56;
        tick();
        check("ljmp_pc3", pc3, 32'h123456);
        check("ljmp_pc2", pc2, 32'h3456);
        check("pchi3", pchi3, 32'h12);
        idle(); local_n = 1'b0; d = 8'hAA;
        tick();
        check("local_pc3", pc3, 32'h1234AA);
        check("local_pclo3", pclo3, 32'hAA);
        check("local_pc2", pc2, 32'h34AA);

        idle(); pchitmp_in_n = 1'b0; d = 8'h00;
        tick();
        idle(); long_n = 1'b0; d = 8'h10;
        tick();
        check("goto_0010", pc2, 32'h0010);
        idle(); hold_n = 1'b0; pchitmp_in_n = 1'b0; d = 8'h20;
        tick();
        check("hold_load_pc", pc2, 32'h0010);
        idle(); call_n = 1'b0; d = 8'h00;
        tick();
        check("call_pc", pc2, 32'h2000);
        check("call_depth", depth2, 32'd1);
        idle();
        tick();
        tick();
        check("sub_inc", pc2, 32'h2002);
        ret_n = 1'b0;
        tick();
        check("ret_pc", pc2, 32'h0011);
        check("ret_depth", depth2, 32'd0);

        idle(); call_n = 1'b0; d = 8'h10;
        tick();
        d = 8'h20;
        tick();
        d = 8'h30;
        tick();
        d = 8'h40;
        tick();
        check("full_noovf", ovf2, 32'd0);
        d = 8'h50;
        tick();
        check("ovf_pc", pc2, 32'h2050);
        check("ovf_depth", depth2, 32'd4);
        check("ovf_flag", ovf2, 32'd1);
        check("ovf_noudf", udf2, 32'd0);

        idle(); ret_n = 1'b0;
        tick();
        check("pop1", pc2, 32'h2031);
        tick();
        check("pop2", pc2, 32'h2021);
        tick();
        check("pop3", pc2, 32'h2011);
        tick();
        check("pop4", pc2, 32'h0012);
        check("pop4_depth", depth2, 32'd0);
        check("pre_udf", udf2, 32'd0);
        tick();
        check("udf_pc", pc2, 32'h0013);
        check("udf_flag", udf2, 32'd1);

        idle(); call_n = 1'b0; d = 8'h60;
        tick();
        check("call60", pc2, 32'h2060);
        idle(); ret_n = 1'b0; call_n = 1'b0; d = 8'h70;
        tick();
        check("prio_pc", pc2, 32'h0014);
        check("prio_depth", depth2, 32'd0);

        idle(); hold_n = 1'b0; long_n = 1'b0;
        pchitmp_in_n = 1'b0; d = 8'h30;
        tick();
        check("hold_pc", pc2, 32'h0014);
        idle(); long_n = 1'b0; d = 8'h05;
        tick();
        check("hold_hitmp", pc2, 32'h3005);
        idle(); long_n = 1'b0; pchitmp_in_n = 1'b0; d = 8'h41;
        tick();
        check("old_hitmp", pc2, 32'h3041);
        idle(); long_n = 1'b0; d = 8'h00;
        tick();
        check("new_hitmp", pc2, 32'h4100);

        idle(); call_n = 1'b0; d = 8'h10;
        tick();
        d = 8'h20;
        tick();
        check("pre_rst_pc", pc2, 32'h4120);
        check("pre_rst_depth", depth2, 32'd2);
        idle();
        #2 mr_n = 1'b0;
        #1;
        check("arst_pc", pc2, 32'h0000);
        check("arst_depth", depth2, 32'd0);
        check("arst_flags", {ovf2, udf2}, 32'd0);
        #1 mr_n = 1'b1;
        tick();
        check("post_rst_pc2", pc2, 32'h0001);
        check("post_rst_pc3", pc3, 32'h000001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
